pwm_timebase: RTL and testbench
===============================

PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 Parameter: N, default 10, width of counter, period and duty values.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: en  input  1  count enable; 0 = counter holds.
REQ-005 Port: wr  input  1  one-cycle strobe; captures period_in/duty_in into shadow registers.
REQ-006 Port: period_in  input  N  requested period; terminal count, unsigned.
REQ-007 Port: duty_in  input  N  requested duty threshold, unsigned.
REQ-008 Port: count_out  output  N  registered counter value; feeds comparator count_in.
REQ-009 Port: duty_out  output  N  active duty register; feeds comparator duty_in.
REQ-010 Port: period_end  output  1  registered one-cycle pulse marking start of a new period.
REQ-011 Port: pending  output  1  high while shadow values await application.

Function
REQ-012 Active registers: period_act and duty_act; duty_out SHALL equal duty_act at all times.
REQ-013 en=1, count_out<period_act: count_out SHALL increment by 1 per clock.
REQ-014 en=1, count_out==period_act ("wrap"): count_out SHALL become 0 next clock.
REQ-015 period_end SHALL be 1 for exactly the clock following each wrap, i.e. coincident with count_out==0 after a wrap; 0 otherwise.
REQ-016 Period length SHALL be period_act+1 clocks; period_act==0 -> count_out stays 0, period_end high every cycle while en=1.
REQ-017 wr=1: period_in/duty_in SHALL load into period_sh/duty_sh and pending SHALL be set next clock.
REQ-018 wr while pending=1: shadow SHALL be overwritten; last write wins; pending stays 1.
REQ-019 At wrap with pending=1: period_act<=period_sh, duty_act<=duty_sh, pending<=0, all on the same edge as count_out->0.
REQ-020 wr on the same cycle as wrap: the wrap SHALL apply the prior shadow contents (if pending); new values load to shadow, pending=1, applied at next wrap.
REQ-021 en=0 with pending=1 and no wr: on next clock, shadow SHALL be applied, count_out forced to 0, pending cleared, period_end not asserted.
REQ-022 en=0 with pending=0: count_out, duty_act, period_act SHALL hold; period_end=0.
REQ-023 Active values SHALL never change mid-period while en=1 (glitch-free duty update).
REQ-024 No width extension: count increment SHALL never exceed period_act, so no overflow; period_act=2^N-1 gives 2^N-clock period.
REQ-025 duty_act==0 yields 0% downstream; duty_act>period_act yields 100%; both legal, no special handling.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) set count_out=0, duty_act=0, period_act=all ones, period_sh=all ones, duty_sh=0, pending=0, period_end=0.
REQ-027 Reset mid-period SHALL discard any pending shadow update; counting resumes from 0 on the first rising edge after rst deasserts with en=1.

Verification
REQ-028 Reset, en=1, no wr, N=10 -> count_out 0..1023 then 0; period_end one cycle at each return to 0; duty_out=0.
REQ-029 en=1, wr period_in=4 duty_in=2 mid-period -> pending=1 until current 1024-cycle period wraps; then count 0,1,2,3,4,0; duty_out=2 from wrap edge; period_end every 5 clocks.
REQ-030 period_act=4, wr period_in=7 on the exact wrap cycle, then wr period_in=9 two cycles later -> first wrap keeps 4; next wrap applies 9; value 7 never active.
REQ-031 en=0 holding count_out=3, wr period_in=2 duty_in=1 -> next clock count_out=0, duty_out=1, pending=0, period_end=0; en=1 -> sequence 0,1,2,0.
REQ-032 period_in=0 applied, en=1 -> count_out constant 0, period_end high every cycle.
REQ-033 rst pulsed asynchronously (between edges) while pending=1 at count_out=6 -> outputs reset values immediately; pending=0; old shadow never applied.

Source files
------------

// File: rtl/pwm_timebase.sv
// Purpose: PWM period/duty timebase; free-running counter with glitch-free shadowed period/duty updates.
// Latency: count_out/period_end are registered (1 clk); a written period/duty becomes active at the next wrap, or one clock later when idle.
// Backpressure: none; wr is always accepted, and a second write before the update is applied overwrites the first (last write wins).
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   en                 - count enable (0 = counter holds)
//   wr                 - strobe capturing period_in/duty_in into shadow registers
//   period_in, duty_in - requested terminal count / duty threshold
//   count_out          - registered counter value for the comparator
//   duty_out           - active duty threshold for the comparator
//   period_end         - one-cycle pulse coincident with count_out==0 after a wrap
//   pending            - shadow values are waiting to be applied
module pwm_timebase #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [N-1:0] period_in,
  input  logic [N-1:0] duty_in,
  output logic [N-1:0] count_out,
  output logic [N-1:0] duty_out,
  output logic         period_end,
  output logic         pending
);

  logic [N-1:0] period_act;
  logic [N-1:0] duty_act;
  logic [N-1:0] period_sh;
  logic [N-1:0] duty_sh;
  logic         wrap;
  logic         idle_apply;
  logic         apply;

  // Terminal count reached while counting; the counter never exceeds
  // period_act, so the increment cannot overflow N bits.
  assign wrap       = en && (count_out == period_act);
  // While stopped there is no period boundary to wait for, so a pending
  // update is taken immediately unless a new write is arriving this cycle.
  assign idle_apply = !en && pending && !wr;
  // The shadow is sampled before this cycle's write lands, so a write on
  // the wrap cycle is deferred to the following wrap.
  assign apply      = pending && (wrap || idle_apply);
  assign duty_out   = duty_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out  <= '0;
      duty_act   <= '0;
      period_act <= '1;
      period_sh  <= '1;
      duty_sh    <= '0;
      pending    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      period_end <= wrap;

      if (en) begin
        count_out <= wrap ? '0 : count_out + 1'b1;
      end else if (idle_apply) begin
        count_out <= '0;
      end

      if (apply) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end

      if (wr) begin
        period_sh <= period_in;
        duty_sh   <= duty_in;
        pending   <= 1'b1;
      end else if (apply) begin
        pending   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_timebase.sv
// Purpose: directed self-checking bench for pwm_timebase (N=10).
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_pwm_timebase;

  localparam int N = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic         wr;
  logic [N-1:0] period_in;
  logic [N-1:0] duty_in;
  logic [N-1:0] count_out;
  logic [N-1:0] duty_out;
  logic         period_end;
  logic         pending;

  int total = 0;
  int bad   = 0;

  pwm_timebase #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr         (wr),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .count_out  (count_out),
    .duty_out   (duty_out),
    .period_end (period_end),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         wr;
    logic [N-1:0] p;
    logic [N-1:0] d;
    logic [N-1:0] ec;
    logic [N-1:0] ed;
    logic         ep;
    logic         epe;
  } vec_t;

  vec_t vec[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int d, input int p, input int pe);
    chk({tag, ".count"},      int'(count_out),  c);
    chk({tag, ".duty"},       int'(duty_out),   d);
    chk({tag, ".pending"},    int'(pending),    p);
    chk({tag, ".period_end"}, int'(period_end), pe);
  endtask

  // Drive inputs, take one rising edge, settle just after it.
  task automatic step(input logic e, input logic w, input int p, input int d);
    en        = e;
    wr        = w;
    period_in = N'(p);
    duty_in   = N'(d);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic w, input int p, input int d,
                              input int c, input int dd, input logic pd, input logic pe);
    vec_t v;
    v.en = e; v.wr = w; v.p = N'(p); v.d = N'(d);
    v.ec = N'(c); v.ed = N'(dd); v.ep = pd; v.epe = pe;
    return v;
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; wr = 1'b0; period_in = '0; duty_in = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1 check_all("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("reset_hold", 0, 0, 0, 0);
    rst = 1'b0;

    // Full 1024-cycle default period; write period=4 duty=2 mid-period.
    for (int i = 1; i <= 1023; i++) begin
      step(1'b1, (i == 500), 4, 2);
      chk("p1024.count", int'(count_out), i);
      chk("p1024.period_end", int'(period_end), 0);
      chk("p1024.pending", int'(pending), (i >= 500) ? 1 : 0);
      chk("p1024.duty", int'(duty_out), 0);
    end
    step(1'b1, 1'b0, 0, 0);
    check_all("p1024.wrap", 0, 2, 0, 1);

    // Table: period 4, wrap-cycle write, overwrite, idle apply, hold, period 0.
    for (int k = 1; k <= 3; k++) vec.push_back(mk(1, 0, 0, 0, k, 2, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 4, 2, 0, 0));
    vec.push_back(mk(1, 1, 7, 3, 0, 2, 1, 1));   // write on wrap cycle: deferred
    vec.push_back(mk(1, 0, 0, 0, 1, 2, 1, 0));
    vec.push_back(mk(1, 1, 9, 5, 2, 2, 1, 0));   // overwrite, 7 never active
    vec.push_back(mk(1, 0, 0, 0, 3, 2, 1, 0));
    vec.push_back(mk(1, 0, 0, 0, 4, 2, 1, 0));
    vec.push_back(mk(1, 0, 0, 0, 0, 5, 0, 1));   // still wrapped at 4, applies 9/5
    for (int k = 1; k <= 9; k++) vec.push_back(mk(1, 0, 0, 0, k, 5, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 0, 5, 0, 1));   // period 9 wrap
    for (int k = 1; k <= 3; k++) vec.push_back(mk(1, 0, 0, 0, k, 5, 0, 0));
    vec.push_back(mk(0, 1, 2, 1, 3, 5, 1, 0));   // stopped at 3, write
    vec.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));   // idle apply, no period_end
    vec.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1));
    vec.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    vec.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));   // hold, nothing pending
    vec.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vec.push_back(mk(0, 1, 0, 0, 1, 1, 1, 0));   // period 0 request
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    vec.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    vec.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));

    foreach (vec[i]) begin
      step(vec[i].en, vec[i].wr, int'(vec[i].p), int'(vec[i].d));
      check_all($sformatf("vec%0d", i), int'(vec[i].ec), int'(vec[i].ed),
                int'(vec[i].ep), int'(vec[i].epe));
    end

    // Asynchronous reset while an update is pending at count 6.
    step(1'b0, 1'b1, 9, 4);
    step(1'b0, 1'b0, 0, 0);
    check_all("pre_rst.apply", 0, 4, 0, 0);
    for (int k = 1; k <= 6; k++) step(1'b1, (k == 2), 3, 7);
    check_all("pre_rst.count6", 6, 4, 1, 0);
    #3 rst = 1'b1;
    #1 check_all("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    // Shadow period 3 must not come back: count runs past 3 on period 1023.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 0, 0);
      check_all($sformatf("post_rst%0d", k), k, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
